// File: rtl/exe_unit_sequencer.sv
// exe_unit_sequencer
//   Command-side master for a fixed-latency 4-op execution unit. It accepts one
//   command at a time, drives and holds the unit's operand bus, waits for the
//   unit's latency, then captures result/status into a response register. The
//   response is offered over valid/ready. Saturating counters track completed
//   responses and responses that carried a non-zero status.
//
// Parameters
//   m    operand/result width
//   n    opcode width
//   LAT  execution-unit latency in clock edges (1..7)
//   CW   completion/error counter width (saturating)
//
// Ports
//   i_clk, i_rsn                         clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready              command handshake (ready only in IDLE)
//   i_cmd_oper/i_cmd_argA/i_cmd_argB     command payload
//   o_oper/o_argA/o_argB                 operand bus to the execution unit
//   i_result/i_status                    execution-unit outputs
//   o_rsp_valid/i_rsp_ready              response handshake
//   o_rsp_oper/o_rsp_result/o_rsp_status response payload
//   o_done_cnt/o_err_cnt                 completed / errored response counters
//   o_busy                               sequencer not idle
module exe_unit_sequencer #(
    parameter int unsigned m   = 4,
    parameter int unsigned n   = 2,
    parameter int unsigned LAT = 1,
    parameter int unsigned CW  = 8
) (
    input  logic          i_clk,
    input  logic          i_rsn,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [n-1:0]  i_cmd_oper,
    input  logic [m-1:0]  i_cmd_argA,
    input  logic [m-1:0]  i_cmd_argB,
    output logic [n-1:0]  o_oper,
    output logic [m-1:0]  o_argA,
    output logic [m-1:0]  o_argB,
    input  logic [m-1:0]  i_result,
    input  logic [3:0]    i_status,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [n-1:0]  o_rsp_oper,
    output logic [m-1:0]  o_rsp_result,
    output logic [3:0]    o_rsp_status,
    output logic [CW-1:0] o_done_cnt,
    output logic [CW-1:0] o_err_cnt,
    output logic          o_busy
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned ST_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [n-1:0]       oper_q,       oper_d;
    logic [m-1:0]       arga_q,       arga_d;
    logic [m-1:0]       argb_q,       argb_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic [n-1:0]       rsp_oper_q,   rsp_oper_d;
    logic [m-1:0]       rsp_result_q, rsp_result_d;
    logic [ST_W-1:0]    rsp_status_q, rsp_status_d;
    logic [CW-1:0]      done_q,       done_d;
    logic [CW-1:0]      err_q,        err_d;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            oper_q       <= '0;
            arga_q       <= '0;
            argb_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_oper_q   <= '0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            oper_q       <= oper_d;
            arga_q       <= arga_d;
            argb_q       <= argb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_oper_q   <= rsp_oper_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        oper_d       = oper_q;
        arga_d       = arga_q;
        argb_d       = argb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_oper_d   = rsp_oper_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        done_d       = done_q;
        err_d        = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    oper_d  = i_cmd_oper;
                    arga_d  = i_cmd_argA;
                    argb_d  = i_cmd_argB;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Operand bus is held; count the unit's latency
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                rsp_oper_d   = oper_q;
                rsp_result_d = i_result;
                rsp_status_d = i_status;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (done_q != '1) begin
                        done_d = done_q + CW'(1);
                    end
                    if ((rsp_status_q != '0) && (err_q != '1)) begin
                        err_d = err_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake readiness depends on state only
    assign o_cmd_ready  = (state_q == ST_IDLE);
    assign o_busy       = (state_q != ST_IDLE);

    assign o_oper       = oper_q;
    assign o_argA       = arga_q;
    assign o_argB       = argb_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_oper   = rsp_oper_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_status = rsp_status_q;
    assign o_done_cnt   = done_q;
    assign o_err_cnt    = err_q;

endmodule
